// File: rtl/lsu_pkg.sv
// Shared types for the load/store memory master.
//   size_e  : access size (byte, half, word, double)
//   err_e   : response error code returned on resp_err
//   state_e : request FSM states
//   is_misaligned() : natural-alignment check for a given size and byte offset
package lsu_pkg;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2,
        SZ_D = 2'd3
    } size_e;

    typedef enum logic [1:0] {
        ERR_OK       = 2'd0,
        ERR_MISALIGN = 2'd1,
        ERR_TIMEOUT  = 2'd2
    } err_e;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StIssue  = 2'd1,
        StRdWait = 2'd2,
        StResp   = 2'd3
    } state_e;

    // An access is misaligned when any of the low log2(size) address bits are set.
    function automatic logic is_misaligned(size_e size, logic [2:0] off);
        logic mis;
        case (size)
            SZ_B:    mis = 1'b0;
            SZ_H:    mis = off[0];
            SZ_W:    mis = |off[1:0];
            default: mis = |off;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational byte-lane steering for an 8-lane (64-bit) data bus.
//   size        in  access size
//   off         in  byte offset within the 8-byte beat (addr[2:0])
//   is_unsigned in  zero-extend loads instead of sign-extending (ignored for D)
//   wdata       in  right-justified store data
//   rdata_raw   in  raw 64-bit beat from memory
//   wmask       out byte-lane mask for the access
//   wdata_lane  out store data shifted into its lanes
//   rdata_ext   out load data extracted from its lanes and extended to 64 bits
module lsu_lane_align
    import lsu_pkg::*;
(
    input  size_e       size,
    input  logic [2:0]  off,
    input  logic        is_unsigned,
    input  logic [63:0] wdata,
    input  logic [63:0] rdata_raw,
    output logic [7:0]  wmask,
    output logic [63:0] wdata_lane,
    output logic [63:0] rdata_ext
);

    logic [5:0]  shamt;
    logic [63:0] rshift;

    assign shamt      = {off, 3'b000};
    assign wdata_lane = wdata << shamt;
    assign rshift     = rdata_raw >> shamt;

    always_comb begin
        wmask     = '0;
        rdata_ext = '0;
        unique case (size)
            SZ_B: begin
                wmask     = 8'h01 << off;
                rdata_ext = {{56{~is_unsigned & rshift[7]}}, rshift[7:0]};
            end
            SZ_H: begin
                wmask     = 8'h03 << off;
                rdata_ext = {{48{~is_unsigned & rshift[15]}}, rshift[15:0]};
            end
            SZ_W: begin
                wmask     = 8'h0F << off;
                rdata_ext = {{32{~is_unsigned & rshift[31]}}, rshift[31:0]};
            end
            SZ_D: begin
                wmask     = 8'hFF;
                rdata_ext = rshift;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/lsu_mem_master.sv
// Load/store initiator between the EXU/MEM stage and the data memory.
// Accepts one request at a time, issues one 8-byte-aligned beat with a byte
// mask, and returns an extended load result or an error code.
//   clk, rst_n                       clock, asynchronous active-low reset
//   req_valid/req_ready              request handshake
//   req_wen/size/unsigned/addr/wdata request fields (registered on accept)
//   resp_valid/resp_ready            response handshake
//   resp_rdata/resp_err              load result (0 for stores/errors), error code
//   data_r_en/data_w_en              memory read/write strobes (ISSUE only)
//   data_wmask/data_addr/data_w      byte mask, aligned address, lane-shifted data
//   mem_ack, mem_rvalid, data_r      memory beat accept, read valid, read data
module lsu_mem_master
    import lsu_pkg::*;
#(
    parameter int unsigned ADDR_W  = 64,
    parameter int unsigned DATA_W  = 64,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wen,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_rdata,
    output logic [1:0]        resp_err,
    output logic              data_r_en,
    output logic              data_w_en,
    output logic [7:0]        data_wmask,
    output logic [ADDR_W-1:0] data_addr,
    output logic [DATA_W-1:0] data_w,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] data_r,
    input  logic              mem_rvalid
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    state_e            state_q, state_d;
    logic              wen_q, wen_d;
    size_e             size_q, size_d;
    logic              uns_q, uns_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    err_e              err_q, err_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic [7:0]        lane_mask;
    logic [DATA_W-1:0] lane_wdata;
    logic [DATA_W-1:0] lane_rdata;
    logic              timeout_hit;
    logic              waiting;

    lsu_lane_align u_lane_align (
        .size        (size_q),
        .off         (addr_q[2:0]),
        .is_unsigned (uns_q),
        .wdata       (wdata_q),
        .rdata_raw   (data_r),
        .wmask       (lane_mask),
        .wdata_lane  (lane_wdata),
        .rdata_ext   (lane_rdata)
    );

    assign waiting = (state_q == StIssue) || (state_q == StRdWait);
    // Counter starts at 0 on entry, so the strobe/wait lasts exactly TIMEOUT cycles.
    assign timeout_hit = waiting && (cnt_q == CNT_W'(TIMEOUT - 1));

    always_comb begin
        state_d = state_q;
        wen_d   = wen_q;
        size_d  = size_q;
        uns_d   = uns_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;

        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    wen_d   = req_wen;
                    size_d  = size_e'(req_size);
                    uns_d   = req_unsigned;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    rdata_d = '0;
                    if (is_misaligned(size_e'(req_size), req_addr[2:0])) begin
                        err_d   = ERR_MISALIGN;
                        state_d = StResp;
                    end else begin
                        err_d   = ERR_OK;
                        state_d = StIssue;
                    end
                end
            end
            StIssue: begin
                if (mem_ack) begin
                    if (wen_q) begin
                        state_d = StResp;
                    end else if (mem_rvalid) begin
                        rdata_d = lane_rdata;
                        state_d = StResp;
                    end else begin
                        state_d = StRdWait;
                    end
                end else if (timeout_hit) begin
                    err_d   = ERR_TIMEOUT;
                    state_d = StResp;
                end
            end
            StRdWait: begin
                if (mem_rvalid) begin
                    rdata_d = lane_rdata;
                    state_d = StResp;
                end else if (timeout_hit) begin
                    err_d   = ERR_TIMEOUT;
                    state_d = StResp;
                end
            end
            StResp: begin
                if (resp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if (state_d != state_q || !waiting) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            wen_q   <= 1'b0;
            size_q  <= SZ_B;
            uns_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= ERR_OK;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            wen_q   <= wen_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    // Strobes decode straight from the state register so reset drops them asynchronously.
    assign req_ready  = (state_q == StIdle);
    assign resp_valid = (state_q == StResp);
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;
    assign data_r_en  = (state_q == StIssue) && !wen_q;
    assign data_w_en  = (state_q == StIssue) && wen_q;
    assign data_wmask = data_w_en ? lane_mask : 8'h00;
    assign data_addr  = {addr_q[ADDR_W-1:3], 3'b000};
    assign data_w     = data_w_en ? lane_wdata : '0;

endmodule

// File: tb/tb_lsu_mem_master.sv
module tb_lsu_mem_master;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_wen, req_unsigned;
    logic [1:0]  req_size;
    logic [63:0] req_addr, req_wdata;
    logic        resp_valid, resp_ready;
    logic [63:0] resp_rdata;
    logic [1:0]  resp_err;
    logic        data_r_en, data_w_en;
    logic [7:0]  data_wmask;
    logic [63:0] data_addr, data_w;
    logic        mem_ack, mem_rvalid;
    logic [63:0] data_r;

    // Second instance with a short timeout; shares clock, reset and request fields.
    logic        req_valid_t, req_ready_t, resp_valid_t, resp_ready_t;
    logic [63:0] resp_rdata_t, data_addr_t, data_w_t, data_r_t;
    logic [1:0]  resp_err_t;
    logic        data_r_en_t, data_w_en_t, mem_ack_t, mem_rvalid_t;
    logic [7:0]  data_wmask_t;

    int n_assert = 0;
    int n_fail   = 0;

    logic [63:0] dev_mem [0:255];
    logic [7:0]  ref_b   [0:2047];

    always #5 clk = ~clk;

    lsu_mem_master dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err), .data_r_en(data_r_en),
        .data_w_en(data_w_en), .data_wmask(data_wmask), .data_addr(data_addr),
        .data_w(data_w), .mem_ack(mem_ack), .data_r(data_r), .mem_rvalid(mem_rvalid)
    );

    lsu_mem_master #(.TIMEOUT(4)) dut_to (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid_t), .req_ready(req_ready_t), .req_wen(req_wen),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid_t), .resp_ready(resp_ready_t),
        .resp_rdata(resp_rdata_t), .resp_err(resp_err_t), .data_r_en(data_r_en_t),
        .data_w_en(data_w_en_t), .data_wmask(data_wmask_t), .data_addr(data_addr_t),
        .data_w(data_w_t), .mem_ack(mem_ack_t), .data_r(data_r_t), .mem_rvalid(mem_rvalid_t)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
        end
    endtask

    // Reference load: assemble n bytes little-endian from the byte memory, then extend.
    function automatic logic [63:0] ref_load(input logic [10:0] a, input int n, input logic uns);
        logic [63:0] v;
        v = 64'd0;
        for (int i = 0; i < n; i++) v = v | (64'(ref_b[a + 11'(i)]) << (8 * i));
        if (!uns && n < 8 && ref_b[a + 11'(n - 1)][7]) v = v - (64'd1 << (8 * n));
        return v;
    endfunction

    task automatic ref_store(input logic [10:0] a, input int n, input logic [63:0] w);
        for (int i = 0; i < n; i++) ref_b[a + 11'(i)] = 8'(w >> (8 * i));
    endtask

    task automatic set_word(input logic [63:0] a, input logic [63:0] w);
        dev_mem[a[10:3]] = w;
        for (int j = 0; j < 8; j++) ref_b[{a[10:3], 3'(j)}] = 8'(w >> (8 * j));
    endtask

    // Runs one request through the main DUT; called and returning at a falling edge.
    // Memory accepts at cycle ack_dly and returns read data at rv_dly (counted from
    // the first cycle after request acceptance); response is accepted after rr_dly waits.
    task automatic run_txn(input logic wen, input logic [1:0] size, input logic uns,
                           input logic [63:0] addr, input logic [63:0] wdata,
                           input int ack_dly, input int rv_dly, input int rr_dly,
                           output logic [63:0] rdata, output logic [1:0] err,
                           output int strobes, output int resp_cycles, output int first_t,
                           output logic proto_ok, output logic [63:0] o_addr,
                           output logic [7:0] o_mask, output logic [63:0] o_wdata);
        logic done;
        logic [63:0] a0, d0, r0;
        logic [7:0]  m0;
        logic [1:0]  e0;
        proto_ok = 1'b1; strobes = 0; resp_cycles = 0; first_t = -1; done = 1'b0;
        a0 = 'x; d0 = 'x; m0 = 'x; r0 = 'x; e0 = 'x;
        if (req_ready !== 1'b1) proto_ok = 1'b0;
        req_valid = 1'b1; req_wen = wen; req_size = size; req_unsigned = uns;
        req_addr = addr; req_wdata = wdata; mem_ack = 1'b0; mem_rvalid = 1'b0; resp_ready = 1'b0;
        @(negedge clk);
        req_valid = 1'b0;
        req_addr = {$urandom, $urandom}; req_wdata = {$urandom, $urandom};
        req_size = 2'($urandom); req_unsigned = 1'($urandom); req_wen = 1'($urandom);
        for (int t = 0; t < 600 && !done; t++) begin
            mem_ack = 1'b0; mem_rvalid = 1'b0; resp_ready = 1'b0;
            if (data_r_en && data_w_en) proto_ok = 1'b0;
            if (!data_w_en && data_wmask !== 8'h00) proto_ok = 1'b0;
            if (req_ready !== 1'b0) proto_ok = 1'b0;
            if (resp_valid) begin
                if (data_r_en || data_w_en) proto_ok = 1'b0;
                if (resp_cycles == 0) begin
                    r0 = resp_rdata; e0 = resp_err; first_t = t;
                end else if (resp_rdata !== r0 || resp_err !== e0) begin
                    proto_ok = 1'b0;
                end
                resp_cycles++;
                if (resp_cycles > rr_dly) begin
                    resp_ready = 1'b1; done = 1'b1;
                end
            end else if (data_r_en || data_w_en) begin
                if (data_w_en !== wen) proto_ok = 1'b0;
                if (strobes == 0) begin
                    a0 = data_addr; m0 = data_wmask; d0 = data_w;
                end else if (data_addr !== a0 || data_wmask !== m0 || data_w !== d0) begin
                    proto_ok = 1'b0;
                end
                strobes++;
                if (data_r_en) data_r = dev_mem[data_addr[10:3]];
                if (t == ack_dly) begin
                    mem_ack = 1'b1;
                    if (data_w_en)
                        for (int j = 0; j < 8; j++)
                            if (data_wmask[j]) dev_mem[data_addr[10:3]][8*j +: 8] = data_w[8*j +: 8];
                end
                if (t == rv_dly) mem_rvalid = 1'b1;
            end else begin
                data_r = dev_mem[a0[10:3]];
                if (t == rv_dly) mem_rvalid = 1'b1;
            end
            @(negedge clk);
        end
        mem_ack = 1'b0; mem_rvalid = 1'b0; resp_ready = 1'b0;
        if (!done) proto_ok = 1'b0;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0) proto_ok = 1'b0;
        rdata = r0; err = e0; o_addr = a0; o_mask = m0; o_wdata = d0;
    endtask

    initial begin
        logic [63:0] rd, oa, od, a, w, exp_v;
        logic [7:0]  om;
        logic [15:0] mtmp;
        logic [1:0]  er, sz;
        logic        pok, uns, wen, mis, got, flag;
        int          st, rc, ft, n, ack_d, rv_d, rr_d, exp_ft;

        rst_n = 1'b0; req_valid = 1'b0; req_wen = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
        req_addr = '0; req_wdata = '0; resp_ready = 1'b0; mem_ack = 1'b0; mem_rvalid = 1'b0;
        data_r = '0; req_valid_t = 1'b0; resp_ready_t = 1'b1; mem_ack_t = 1'b0;
        mem_rvalid_t = 1'b0; data_r_t = '0;
        for (int i = 0; i < 256; i++) set_word({53'd0, 8'(i), 3'd0}, {$urandom, $urandom});

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst req_ready", 64'(req_ready), 64'd1);
        chk("rst resp_valid", 64'(resp_valid), 64'd0);
        chk("rst resp_err", 64'(resp_err), 64'd0);
        chk("rst resp_rdata", resp_rdata, 64'd0);
        chk("rst strobes", 64'({data_r_en, data_w_en}), 64'd0);
        chk("rst wmask", 64'(data_wmask), 64'd0);
        chk("rst data_addr", data_addr, 64'd0);
        chk("rst data_w", data_w, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // SD aligned double
        run_txn(1'b1, 2'd3, 1'b0, 64'h8000_0008, 64'h1122_3344_5566_7788, 0, 0, 0,
                rd, er, st, rc, ft, pok, oa, om, od);
        ref_store(11'h008, 8, 64'h1122_3344_5566_7788);
        chk("SD wmask", 64'(om), 64'hFF);
        chk("SD data_w", od, 64'h1122_3344_5566_7788);
        chk("SD data_addr", oa, 64'h8000_0008);
        chk("SD err", 64'(er), 64'd0);
        chk("SD latency", 64'(ft), 64'd1);
        chk("SD protocol", 64'(pok), 64'd1);

        // SB at byte 3
        run_txn(1'b1, 2'd0, 1'b0, 64'h8000_0003, 64'hAB, 0, 0, 0, rd, er, st, rc, ft, pok, oa, om, od);
        ref_store(11'h003, 1, 64'hAB);
        chk("SB wmask", 64'(om), 64'h08);
        chk("SB data_w", od, 64'h0000_0000_AB00_0000);
        chk("SB data_addr", oa, 64'h8000_0000);
        chk("SB protocol", 64'(pok), 64'd1);

        // LH / LHU from the top half-word
        set_word(64'h8000_0000, 64'h8001_0000_0000_0000);
        run_txn(1'b0, 2'd1, 1'b0, 64'h8000_0006, 64'd0, 0, 0, 0, rd, er, st, rc, ft, pok, oa, om, od);
        chk("LH rdata", rd, 64'hFFFF_FFFF_FFFF_8001);
        chk("LH err", 64'(er), 64'd0);
        chk("LH protocol", 64'(pok), 64'd1);
        run_txn(1'b0, 2'd1, 1'b1, 64'h8000_0006, 64'd0, 0, 0, 0, rd, er, st, rc, ft, pok, oa, om, od);
        chk("LHU rdata", rd, 64'h0000_0000_0000_8001);

        // Misaligned LW
        run_txn(1'b0, 2'd2, 1'b0, 64'h8000_0002, 64'd0, 0, 0, 0, rd, er, st, rc, ft, pok, oa, om, od);
        chk("LW misalign err", 64'(er), 64'd1);
        chk("LW misalign strobes", 64'(st), 64'd0);
        chk("LW misalign rdata", rd, 64'd0);
        chk("LW misalign protocol", 64'(pok), 64'd1);

        // Slow memory: ack at +3, rvalid at +5, response stalled 2 cycles
        exp_v = ref_load(11'h010, 8, 1'b0);
        run_txn(1'b0, 2'd3, 1'b0, 64'h8000_0010, 64'd0, 3, 5, 2, rd, er, st, rc, ft, pok, oa, om, od);
        chk("slow rdata", rd, exp_v);
        chk("slow strobe cycles", 64'(st), 64'd4);
        chk("slow resp held", 64'(rc), 64'd3);
        chk("slow resp time", 64'(ft), 64'd6);
        chk("slow protocol", 64'(pok), 64'd1);

        // Back-to-back SW then LW at the same address
        w = {$urandom, $urandom};
        run_txn(1'b1, 2'd2, 1'b0, 64'h8000_0104, w, 0, 0, 0, rd, er, st, rc, ft, pok, oa, om, od);
        ref_store(11'h104, 4, w);
        chk("b2b SW protocol", 64'(pok), 64'd1);
        run_txn(1'b0, 2'd2, 1'b0, 64'h8000_0104, 64'd0, 0, 0, 0, rd, er, st, rc, ft, pok, oa, om, od);
        chk("b2b LW rdata", rd, {{32{w[31]}}, w[31:0]});
        chk("b2b LW protocol", 64'(pok), 64'd1);

        // Timeout instance: memory never acknowledges
        req_wen = 1'b0; req_size = 2'd3; req_unsigned = 1'b0; req_addr = 64'h8000_0000;
        req_valid_t = 1'b1;
        @(negedge clk);
        req_valid_t = 1'b0; got = 1'b0; st = 0; flag = 1'b1; rd = 'x; er = 'x;
        for (int i = 0; i < 40 && !got; i++) begin
            if (data_w_en_t || data_wmask_t !== 8'h00 || data_w_t !== 64'd0 || req_ready_t) flag = 1'b0;
            if (resp_valid_t) begin
                got = 1'b1; rd = resp_rdata_t; er = resp_err_t;
                if (data_r_en_t) flag = 1'b0;
            end else if (data_r_en_t) begin
                st++;
                if (data_addr_t !== 64'h8000_0000) flag = 1'b0;
            end
            @(negedge clk);
        end
        chk("timeout resp seen", 64'(got), 64'd1);
        chk("timeout err", 64'(er), 64'd2);
        chk("timeout rdata", rd, 64'd0);
        chk("timeout strobe cycles", 64'(st), 64'd4);
        chk("timeout protocol", 64'(flag), 64'd1);
        chk("timeout back to idle", 64'(req_ready_t), 64'd1);

        // Late mem_rvalid in IDLE is ignored
        mem_rvalid = 1'b1; data_r = {$urandom, $urandom};
        @(negedge clk);
        mem_rvalid = 1'b0; flag = 1'b1;
        repeat (3) begin
            if (resp_valid !== 1'b0 || req_ready !== 1'b1) flag = 1'b0;
            @(negedge clk);
        end
        chk("late rvalid ignored", 64'(flag), 64'd1);

        // Reset during ISSUE: strobe drops without a clock edge
        req_wen = 1'b0; req_size = 2'd3; req_addr = 64'h8000_0020; req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        chk("issue strobe before reset", 64'(data_r_en), 64'd1);
        #2 rst_n = 1'b0;
        #1 chk("reset in issue strobe", 64'({data_r_en, data_w_en}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Reset during RDWAIT, then stale read data after release
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0; mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        chk("rdwait no strobe/resp", 64'({data_r_en, resp_valid}), 64'd0);
        #2 rst_n = 1'b0;
        #1 chk("reset in rdwait outputs", 64'({data_r_en, data_w_en, resp_valid}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1; mem_rvalid = 1'b1;
        @(negedge clk);
        mem_rvalid = 1'b0; flag = 1'b1;
        repeat (3) begin
            if (resp_valid !== 1'b0 || req_ready !== 1'b1) flag = 1'b0;
            @(negedge clk);
        end
        chk("after reset idle, no resp", 64'(flag), 64'd1);

        // Random traffic against the byte-memory reference
        for (int k = 0; k < 60; k++) begin
            sz  = 2'($urandom_range(0, 3));
            n   = 1 << sz;
            wen = 1'($urandom);
            uns = 1'($urandom);
            a   = 64'h8000_0000 + 64'($urandom_range(0, 2047));
            mis = (sz != 2'd0) && ($urandom_range(0, 7) == 0);
            if (!mis) a = a & ~64'(n - 1);
            else if ((a & 64'(n - 1)) == 64'd0) a = a + 64'd1;
            w     = {$urandom, $urandom};
            ack_d = $urandom_range(0, 2);
            rv_d  = ack_d + $urandom_range(0, 2);
            rr_d  = $urandom_range(0, 2);
            exp_v = (wen || mis) ? 64'd0 : ref_load(a[10:0], n, uns);
            exp_ft = mis ? 0 : (wen ? ack_d + 1 : rv_d + 1);
            run_txn(wen, sz, uns, a, w, ack_d, rv_d, rr_d, rd, er, st, rc, ft, pok, oa, om, od);
            chk("rnd protocol", 64'(pok), 64'd1);
            chk("rnd err", 64'(er), mis ? 64'd1 : 64'd0);
            chk("rnd rdata", rd, exp_v);
            chk("rnd resp time", 64'(ft), 64'(exp_ft));
            chk("rnd strobe cycles", 64'(st), mis ? 64'd0 : 64'(ack_d + 1));
            if (!mis) begin
                chk("rnd data_addr", oa, a & ~64'h7);
                if (wen) begin
                    mtmp = ((16'd1 << n) - 16'd1) << a[2:0];
                    chk("rnd wmask", 64'(om), 64'(mtmp[7:0]));
                    chk("rnd data_w", od, w << (8 * a[2:0]));
                    ref_store(a[10:0], n, w);
                end
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
